// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl: shares one combinational ALU between two requesters.
// Optional macro ALU_SHARE_RR_EN selects round-robin tie-break (else req0 wins).
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   reqN_valid/ready    operation handshake (N = 0,1)
//   reqN_op/a/b/setcc   operation: 00 add, 01 sub, 10 and, 11 xor
//   rspN_valid/ready    result handshake for the granted requester
//   rsp_data, rsp_of    registered result and masked overflow
//   alu_control/a/b     registered drive to the shared ALU
//   alu_out, alu_of     ALU result and raw overflow
//   cc_zf/sf/of         condition-code register
//   busy                a transaction is in flight
module alu_share_ctrl #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [1:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_setcc,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [1:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_setcc,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_of,
  output logic [1:0]       alu_control,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_of,
  output logic             cc_zf,
  output logic             cc_sf,
  output logic             cc_of,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state;

  logic last_grant;
  logic gnt_id;
  logic op_setcc;
  logic tie_pick;
  logic win_id;
  logic accept;
  logic of_masked;
  logic rsp_take;

  // Tie-break when both requesters are valid.
`ifdef ALU_SHARE_RR_EN
  assign tie_pick = ~last_grant;
`else
  // last_grant is still tracked but never steers the choice.
  assign tie_pick = last_grant & 1'b0;
`endif

  always_comb begin
    win_id = 1'b0;
    unique case (1'b1)
      (req0_valid && req1_valid):  win_id = tie_pick;
      (req1_valid && !req0_valid): win_id = 1'b1;
      default:                     win_id = 1'b0;
    endcase
  end

  // Ready is gated by rst so a request held across reset is never taken.
  assign req0_ready = !rst && (state == IDLE) &&
                      req0_valid && !win_id;
  assign req1_ready = !rst && (state == IDLE) &&
                      req1_valid && win_id;
  assign accept = req0_ready | req1_ready;

  // Logic ops have no meaningful overflow.
  assign of_masked = alu_control[1] ? 1'b0 : alu_of;

  assign rsp_take = gnt_id ? rsp1_ready : rsp0_ready;

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      last_grant  <= 1'b1;
      gnt_id      <= 1'b0;
      op_setcc    <= 1'b0;
      alu_control <= 2'b00;
      alu_a       <= '0;
      alu_b       <= '0;
      rsp_data    <= '0;
      rsp_of      <= 1'b0;
      rsp0_valid  <= 1'b0;
      rsp1_valid  <= 1'b0;
      cc_zf       <= 1'b1;
      cc_sf       <= 1'b0;
      cc_of       <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            alu_control <= win_id ? req1_op : req0_op;
            alu_a       <= win_id ? req1_a : req0_a;
            alu_b       <= win_id ? req1_b : req0_b;
            op_setcc    <= win_id ? req1_setcc
                                  : req0_setcc;
            gnt_id      <= win_id;
            last_grant  <= win_id;
            state       <= EXEC;
          end
        end
        EXEC: begin
          rsp_data   <= alu_out;
          rsp_of     <= of_masked;
          rsp0_valid <= !gnt_id;
          rsp1_valid <= gnt_id;
          if (op_setcc) begin
            cc_zf <= (alu_out == '0);
            cc_sf <= alu_out[WIDTH-1];
            cc_of <= of_masked;
          end
          state <= RESP;
        end
        RESP: begin
          if (rsp_take) begin
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: begin
          rsp0_valid <= 1'b0;
          rsp1_valid <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule
